// File: rtl/cnn_acc_requant_25s_10s.sv
// Accumulates one output pixel's products onto a bias, then rounds, shifts
// and saturates the sum to OUT_W-bit signed fixed point behind valid/ready.
module cnn_acc_requant_25s_10s #(
    parameter int PROD_W     = 25,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 10,
    parameter int BIAS_W     = 14,
    parameter int N_TERMS    = 25,
    parameter int FRAC_SHIFT = 9
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W:0] R_MAX = (ACC_W + 1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W:0] R_MIN = (ACC_W + 1)'(-(2 ** (OUT_W - 1)));
    localparam logic [OUT_W-1:0] D_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] D_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;

    logic                    accept;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W:0]   rsum;
    logic signed [ACC_W:0]   rshift;

    assign in_ready = (state == IDLE) || (state == ACC);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    assign prod_ext = {{(ACC_W - PROD_W){in_prod[PROD_W-1]}}, in_prod};
    assign bias_ext = {{(ACC_W - BIAS_W){bias[BIAS_W-1]}}, bias} << FRAC_SHIFT;

    // One extra bit keeps the rounding offset from wrapping a near-full acc.
    assign rsum   = {acc[ACC_W-1], acc} + $signed(HALF);
    assign rshift = rsum >>> FRAC_SHIFT;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= bias_ext + prod_ext;
                        cnt   <= CNT_W'(1);
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(N_TERMS - 1)) begin
                            state <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    if (rshift > R_MAX) begin
                        out_data <= D_MAX;
                        out_sat  <= 1'b1;
                    end else if (rshift < R_MIN) begin
                        out_data <= D_MIN;
                        out_sat  <= 1'b1;
                    end else begin
                        out_data <= rshift[OUT_W-1:0];
                        out_sat  <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_acc_requant_25s_10s.sv
// Directed self-checking bench for cnn_acc_requant_25s_10s: arithmetic,
// rounding, saturation, bias, flow control and mid-packet reset.
module tb_cnn_acc_requant_25s_10s;

    logic               ap_clk;
    logic               ap_rst_n;
    logic signed [13:0] bias;
    logic signed [24:0] in_prod;
    logic               in_valid;
    logic               in_ready;
    logic signed [9:0]  out_data;
    logic               out_sat;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    int testsRun = 0;
    int testsFailed = 0;

    cnn_acc_requant_25s_10s dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .bias      (bias),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Present one term after an optional idle gap and hold it until accepted.
    task automatic applyStimulus(input logic signed [24:0] p, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_prod  = p;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic sendPacket(input logic signed [13:0] b, input logic signed [24:0] p,
                              input logic signed [24:0] lastP, input bit gaps);
        bias = b;
        for (int i = 0; i < 24; i++) applyStimulus(p, gaps ? int'($urandom_range(0, 3)) : 0);
        applyStimulus(lastP, gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic checkOutput(input string tag, input int expData, input int expSat);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_data"}, int'(out_data), expData);
        check({tag, "_sat"}, int'(out_sat), expSat);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_released"}, int'(out_valid), 0);
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        bias      = '0;
        in_prod   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sat", int'(out_sat), 0);
        tick();
        tick();
        ap_rst_n = 1'b1;
        tick();

        // 25 x 512 back-to-back, with latency from the last accept
        sendPacket(14'sd0, 25'sd512, 25'sd512, 1'b0);
        check("lat_round_cycle", int'(out_valid), 0);
        check("lat_busy", int'(busy), 1);
        tick();
        check("lat_out_cycle", int'(out_valid), 1);
        checkOutput("basic", 25, 0);

        sendPacket(14'sd0, 25'sd0, 25'sd256, 1'b0);
        checkOutput("round_p256", 1, 0);
        sendPacket(14'sd0, 25'sd0, -25'sd256, 1'b0);
        checkOutput("round_m256", 0, 0);
        sendPacket(14'sd0, 25'sd0, -25'sd257, 1'b0);
        checkOutput("round_m257", -1, 0);

        sendPacket(14'sd0, 25'sd1048576, 25'sd1048576, 1'b0);
        checkOutput("sat_pos", 511, 1);
        sendPacket(14'sd0, -25'sd1048576, -25'sd1048576, 1'b0);
        checkOutput("sat_neg", -512, 1);
        sendPacket(14'sd0, 25'sd10475, 25'sd10475, 1'b0);
        checkOutput("near_max", 511, 0);

        sendPacket(14'sd3, 25'sd0, 25'sd0, 1'b0);
        checkOutput("bias_p3", 3, 0);
        sendPacket(-14'sd600, 25'sd0, 25'sd0, 1'b0);
        checkOutput("bias_m600", -512, 1);

        sendPacket(14'sd0, 25'sd512, 25'sd512, 1'b1);
        checkOutput("gaps", 25, 0);

        // Backpressure: hold out_ready low while upstream offers the next term
        sendPacket(14'sd0, -25'sd1048576, -25'sd1048576, 1'b0);
        tick();
        bias     = 14'sd3;
        in_prod  = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), -512);
            check("hold_sat", int'(out_sat), 1);
            check("hold_in_ready", int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", int'(out_valid), 0);
        check("release_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("next_first_accepted", int'(busy), 1);
        for (int i = 0; i < 24; i++) applyStimulus(25'sd0, 0);
        checkOutput("after_hold", 3, 0);

        // Reset after 12 terms discards the partial sum
        bias = 14'sd0;
        for (int i = 0; i < 12; i++) applyStimulus(25'sd1048576, 0);
        check("pre_reset_busy", int'(busy), 1);
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        tick();
        tick();
        ap_rst_n = 1'b1;
        tick();
        check("post_rst_out_valid", int'(out_valid), 0);
        sendPacket(14'sd0, 25'sd512, 25'sd512, 1'b0);
        checkOutput("after_reset", 25, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
